// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmed number of high/low pulses on `add`
// through a start/busy/done handshake.
//
// Optional feature: define PULSE_ABORT_EN to add the `abort` input, which
// cuts a running train short and jumps straight to the completion strobe.
//
// All outputs come straight from flops. Their next values are decoded from
// the next state, so there is no combinational path from input to output.
module pulse_train_gen #(
    parameter int COUNT_WIDTH = 9,
    parameter int HIGH_CYCLES = 1,
    parameter int LOW_CYCLES  = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count,
`ifdef PULSE_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   add,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] pulses_sent
);

    localparam int MAX_PHASE   = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TIMER_WIDTH = $clog2(MAX_PHASE + 1);

    // Each phase timer is loaded with (cycles - 1) and counts down to zero,
    // so the phase lasts exactly its programmed number of cycles.
    localparam logic [TIMER_WIDTH-1:0] HIGH_RELOAD = TIMER_WIDTH'(HIGH_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] LOW_RELOAD  = TIMER_WIDTH'(LOW_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO  = {TIMER_WIDTH{1'b0}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0] pulses_sent_q, pulses_sent_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   add_q, add_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   abort_s;

`ifdef PULSE_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        pulses_sent_d = pulses_sent_q;
        timer_d       = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pulses_sent_d = COUNT_ZERO;
                    if (count != COUNT_ZERO) begin
                        remaining_d = count;
                        timer_d     = HIGH_RELOAD;
                        state_d     = ST_HIGH;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (abort_s) begin
                    // A truncated high phase is not counted as a pulse.
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_ZERO) begin
                    remaining_d   = remaining_q - COUNT_ONE;
                    pulses_sent_d = pulses_sent_q + COUNT_ONE;
                    timer_d       = LOW_RELOAD;
                    state_d       = ST_LOW;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_LOW: begin
                if (abort_s) begin
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_ZERO) begin
                    if (remaining_q != COUNT_ZERO) begin
                        timer_d = HIGH_RELOAD;
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_DONE: begin
                remaining_d = COUNT_ZERO;
                timer_d     = TIMER_ZERO;
                state_d     = ST_IDLE;
            end
            default: begin
                remaining_d = COUNT_ZERO;
                timer_d     = TIMER_ZERO;
                state_d     = ST_IDLE;
            end
        endcase

        add_d  = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and output flops; reset drops add immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            remaining_q   <= COUNT_ZERO;
            pulses_sent_q <= COUNT_ZERO;
            timer_q       <= TIMER_ZERO;
            add_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            pulses_sent_q <= pulses_sent_d;
            timer_q       <= timer_d;
            add_q         <= add_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign add         = add_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = pulses_sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: per-cycle expected outputs are queued when a
// train is started and compared against the DUT on each falling clock edge.
// A second instance with HIGH_CYCLES=2, LOW_CYCLES=3 exercises the phase timer.
module tb_pulse_train_gen;

    typedef struct {
        logic       add;
        logic       busy;
        logic       done;
        logic [8:0] pulses;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, start2;
    logic [8:0] count, count2;
`ifdef PULSE_ABORT_EN
    logic       abort;
`endif
    logic       add, busy, done;
    logic [8:0] pulses_sent;
    logic       add2, busy2, done2;
    logic [8:0] pulses_sent2;

    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side model of an 8-bit counter fed by add; held at its
    // "reset then two increments" value (2) while counting is disabled.
    logic       cnt_en;
    logic [7:0] cnt_m;
    logic       carry_m;
    logic       add_prev;

    pulse_train_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .count       (count),
`ifdef PULSE_ABORT_EN
        .abort       (abort),
`endif
        .add         (add),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    pulse_train_gen #(.COUNT_WIDTH(9), .HIGH_CYCLES(2), .LOW_CYCLES(3)) dut2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start2),
        .count       (count2),
`ifdef PULSE_ABORT_EN
        .abort       (1'b0),
`endif
        .add         (add2),
        .busy        (busy2),
        .done        (done2),
        .pulses_sent (pulses_sent2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue the expected per-cycle outputs of one train; abort_at is the index
    // of the pulse whose high phase is aborted (-1 for none).
    task automatic push_train(input int sel, input int n, input int hi, input int lo, input int abort_at);
        exp_t e;
        int   fin;
        fin = n;
        for (int k = 0; k < n; k++) begin
            for (int h = 0; h < hi; h++) begin
                e = '{add: 1'b1, busy: 1'b1, done: 1'b0, pulses: 9'(k)};
                if (sel == 1) q1.push_back(e); else q2.push_back(e);
            end
            if (k == abort_at) begin
                fin = k;
                break;
            end
            for (int l = 0; l < lo; l++) begin
                e = '{add: 1'b0, busy: 1'b1, done: 1'b0, pulses: 9'(k + 1)};
                if (sel == 1) q1.push_back(e); else q2.push_back(e);
            end
        end
        e = '{add: 1'b0, busy: 1'b1, done: 1'b1, pulses: 9'(fin)};
        if (sel == 1) q1.push_back(e); else q2.push_back(e);
        e = '{add: 1'b0, busy: 1'b0, done: 1'b0, pulses: 9'(fin)};
        if (sel == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    // Present a start request for one cycle; returns just after the accepting edge.
    task automatic start_train(input int n);
        @(negedge clock);
        count = 9'(n);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clock);
        @(negedge clock);
        check(tag, ((q1.size() == 0) && (q2.size() == 0)) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Scoreboard compare for the default-parameter instance.
    always @(negedge clock) begin : mon1
        exp_t e;
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("add", add, e.add);
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("pulses_sent", pulses_sent, e.pulses);
        end
    end

    // Scoreboard compare for the long-phase instance.
    always @(negedge clock) begin : mon2
        exp_t e;
        if (q2.size() != 0) begin
            e = q2.pop_front();
            check("add2", add2, e.add);
            check("busy2", busy2, e.busy);
            check("done2", done2, e.done);
            check("pulses_sent2", pulses_sent2, e.pulses);
        end
    end

    // Counter model: counts rising edges of add, sticky carry on wrap.
    always @(negedge clock) begin
        if (!cnt_en) begin
            cnt_m   = 8'd2;
            carry_m = 1'b0;
        end else if (add && !add_prev) begin
            if (cnt_m == 8'hFF) carry_m = 1'b1;
            cnt_m = cnt_m + 8'd1;
        end
        add_prev = add;
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        count   = 9'd3;
        start2  = 1'b0;
        count2  = 9'd0;
        cnt_en  = 1'b0;
`ifdef PULSE_ABORT_EN
        abort   = 1'b0;
`endif

        // Reset held with start asserted: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst_add", add, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_pulses", pulses_sent, 9'd0);
        end
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Two-pulse train.
        start_train(2);
        push_train(1, 2, 1, 1, -1);
        drain("two_pulse_drain");

        // 256 pulses wrap an 8-bit counter preloaded with 2.
        cnt_en = 1'b1;
        start_train(256);
        push_train(1, 256, 1, 1, -1);
        drain("wrap_drain");
        check("wrap_pulses", pulses_sent, 9'd256);
        check("wrap_cnt", cnt_m, 8'd2);
        check("wrap_carry", carry_m, 1'b1);
        cnt_en = 1'b0;

        // Zero count: immediate done, no pulse.
        start_train(0);
        push_train(1, 0, 1, 1, -1);
        drain("zero_drain");

        // Start and a new count during a running train are ignored.
        start_train(5);
        push_train(1, 5, 1, 1, -1);
        @(negedge clock);
        @(negedge clock);
        start = 1'b1;
        count = 9'd7;
        @(negedge clock);
        start = 1'b0;
        drain("ignored_start_drain");

        // Reset asserted during the fourth high phase.
        start_train(10);
        push_train(1, 10, 1, 1, -1);
        repeat (7) @(negedge clock);
        check("pre_rst_add", add, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_add", add, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_pulses", pulses_sent, 9'd0);
        q1.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) q1.push_back('{add: 1'b0, busy: 1'b0, done: 1'b0, pulses: 9'd0});
        drain("midrst_drain");

`ifdef PULSE_ABORT_EN
        // Abort during the third high phase.
        start_train(10);
        push_train(1, 10, 1, 1, 2);
        repeat (5) @(negedge clock);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        drain("abort_drain");
`endif

        // Longer phases on the second instance: 3 pulses, 2 high / 3 low.
        @(negedge clock);
        count2 = 9'd3;
        start2 = 1'b1;
        @(posedge clock);
        #1;
        start2 = 1'b0;
        push_train(2, 3, 2, 3, -1);
        drain("long_phase_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
